// File: rtl/mux2_rr_arb_if.sv
`default_nettype none
// ============================================================================
// mux2_rr_arb_if : requester A/B and downstream C valid/ready bundle (rev 1.0)
// ============================================================================
interface mux2_rr_arb_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;
  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;
  logic                  c_valid;
  logic [DATA_WIDTH-1:0] c_data;
  logic                  c_src;
  logic                  c_ready;
`ifdef MUX2_ARB_LOCK_EN
  logic                  a_last;
  logic                  b_last;
`endif

  // Arbiter side
  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_ready,
`ifdef MUX2_ARB_LOCK_EN
    input  a_last, b_last,
`endif
    output a_ready, b_ready, c_valid, c_data, c_src
  );

  // Requester / consumer side
  modport master (
    output a_valid, a_data, b_valid, b_data, c_ready,
`ifdef MUX2_ARB_LOCK_EN
    output a_last, b_last,
`endif
    input  a_ready, b_ready, c_valid, c_data, c_src
  );
endinterface
`default_nettype wire

// File: rtl/mux2_rr_arb.sv
`default_nettype none
// ============================================================================
// mux2_rr_arb : round-robin 2:1 arbiter with one-entry output stage; optional
//               burst locking via MUX2_ARB_LOCK_EN (rev 1.0)
// ============================================================================
module mux2_rr_arb #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  mux2_rr_arb_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_src;
  logic                  r_prio;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_elig_a;
  logic                  w_elig_b;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_can_load;
  logic                  w_accept;
`ifdef MUX2_ARB_LOCK_EN
  logic                  r_lock;
  logic                  r_lock_a;
  logic                  w_last;
`endif

  always_comb begin
    w_elig_a    = bus.a_valid;
    w_elig_b    = bus.b_valid;
`ifdef MUX2_ARB_LOCK_EN
    // A burst in progress masks the other side, even if it is favoured.
    if (r_lock) begin
      w_elig_a = bus.a_valid & r_lock_a;
      w_elig_b = bus.b_valid & ~r_lock_a;
    end
`endif
    w_gnt_a     = w_elig_a & (~w_elig_b | ~r_prio);
    w_gnt_b     = w_elig_b & (~w_elig_a |  r_prio);
    w_can_load  = rst_n & ((r_state == ST_EMPTY) | bus.c_ready);
    w_accept    = w_can_load & (w_gnt_a | w_gnt_b);
    w_word      = w_gnt_a ? bus.a_data : bus.b_data;
`ifdef MUX2_ARB_LOCK_EN
    w_last      = w_gnt_a ? bus.a_last : bus.b_last;
`endif
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_FULL;
    end else if (bus.c_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_src    <= 1'b0;
      r_prio   <= 1'b0;
`ifdef MUX2_ARB_LOCK_EN
      r_lock   <= 1'b0;
      r_lock_a <= 1'b0;
`endif
    end else if (w_accept) begin
      r_data <= w_word;
      r_src  <= w_gnt_a;
`ifdef MUX2_ARB_LOCK_EN
      // A whole burst counts as one turn: priority moves only on its last beat.
      if (w_last) begin
        r_prio <= w_gnt_a;
        r_lock <= 1'b0;
      end else begin
        r_lock   <= 1'b1;
        r_lock_a <= w_gnt_a;
      end
`else
      r_prio <= w_gnt_a;
`endif
    end
  end

  assign bus.a_ready = w_can_load & w_gnt_a;
  assign bus.b_ready = w_can_load & w_gnt_b;
  assign bus.c_valid = (r_state == ST_FULL);
  assign bus.c_data  = r_data;
  assign bus.c_src   = r_src;

endmodule
`default_nettype wire
